// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU arbiter.
// The arbiter takes the slave side; requesters, ALU and consumer take master.
interface alu_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [2:0]           alu_op;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [31:0]          alu_result;
    logic                 alu_carry;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_carry;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_carry, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_data, rsp_carry
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_carry, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters,
// with a one-entry tagged response register on a valid/ready channel.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    data_q, data_d;
    logic           carry_q, carry_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic           slot_free;
    logic           hi_found, lo_found;
    logic [IDW-1:0] hi_id, lo_id;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;

    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // First requester above last grant wins, else lowest index (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && !hi_found && (IDW'(i) > last_q)) begin
                hi_found = 1'b1;
                hi_id    = IDW'(i);
            end
            if (bus.req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = IDW'(i);
            end
        end
    end

    assign gnt_vld = rst_n && slot_free && lo_found;
    assign gnt_id  = hi_found ? hi_id : lo_id;

    always_comb begin
        bus.req_ready = '0;
        bus.alu_op    = 3'b000;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && (gnt_id == IDW'(i))) begin
                bus.req_ready[i] = 1'b1;
                bus.alu_op       = bus.req_op[3*i +: 3];
                bus.alu_a        = bus.req_a[32*i +: 32];
                bus.alu_b        = bus.req_b[32*i +: 32];
            end
        end
    end

    // A new accept overwrites a draining response in the same cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        id_d        = id_q;
        data_d      = data_q;
        carry_d     = carry_q;
        last_d      = last_q;
        if (gnt_vld) begin
            rsp_valid_d = 1'b1;
            id_d        = gnt_id;
            data_d      = bus.alu_result;
            carry_d     = bus.alu_carry;
            last_d      = gnt_id;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            id_q        <= '0;
            data_q      <= '0;
            carry_q     <= 1'b0;
            last_q      <= IDW'(NREQ - 1);
        end else begin
            rsp_valid_q <= rsp_valid_d;
            id_q        <= id_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            last_q      <= last_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_carry = carry_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter that shares the single combinational 32-bit ALU between NREQ independent requesters, e.g. the main execute path, the branch-target adder and the address-generation unit.
- Each requester presents op/A/B with a valid/ready handshake.
- The arbiter drives the ALU inputs from the granted requester and captures alu_out/carry_out into a one-entry response register tagged with the requester ID.
- Results return on a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters; legal 2..4.
- IDW, 2, width of the requester ID tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  in  3*NREQ  ALU op for requester i, at bits [3i+2:3i].
- req_a  in  32*NREQ  operand A for requester i, at bits [32i+31:32i].
- req_b  in  32*NREQ  operand B for requester i, same packing as req_a.
- alu_op  out  3  to the ALU: bit2 inverts B; bits[1:0] select 10=add, 00=and, 01=or, 11=all-ones.
- alu_a  out  32  to the ALU operand A.
- alu_b  out  32  to the ALU operand B.
- alu_result  in  32  from the ALU result.
- alu_carry  in  1  from the ALU carry out.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  32  captured ALU result.
- rsp_carry  out  1  captured ALU carry.

Behaviour:
- Reset (async, rst_n low):
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has top priority after reset.
  - Reset asserted mid-operation discards any held response. No req_ready is asserted while rst_n is low.
- Slot availability: slot_free = !rsp_valid | rsp_ready.
- Grant (combinational):
  - Only when slot_free, pick the first i with req_valid[i], searching (last_grant+1) mod NREQ upward with wrap.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - If slot_free=0 or no request is valid, req_ready=0.
- ALU drive (combinational):
  - With a grant active, alu_op/alu_a/alu_b equal the granted requester's fields.
  - With no grant, drive alu_op=3'b000, alu_a=0, alu_b=0 (quiet, deterministic).
- Accept (req_valid[i] & req_ready[i] at a rising edge):
  - rsp_data<=alu_result, rsp_carry<=alu_carry, rsp_id<=i, rsp_valid<=1, last_grant<=i.
  - Latency: the response is visible the cycle after acceptance (1 cycle).
- Response drain:
  - rsp_valid & rsp_ready with no new accept: rsp_valid<=0.
  - Drain and accept in the same cycle: the register is overwritten with the new result, rsp_valid stays 1. Full throughput is 1 op/cycle.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0 blocks all grants.
  - rsp_* fields hold stable until the response is drained.
  - last_grant does not move while stalled.
- Fairness:
  - With all NREQ requesting continuously and rsp_ready=1, grants rotate 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ-1 accepts.
- Arithmetic: the arbiter does not interpret op. Data and carry pass through unmodified. op=3'b110 yields A+~B (carry-out included) exactly as the ALU computes it.
- Requesters may drop req_valid without having been granted; nothing is latched until accept.

Test Plan:
- Reset release, only req_valid[0]=1, op=3'b010, A=0x00000005, B=0x00000003 -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x00000008, rsp_carry=0.
- Only req1 valid, op=3'b110, A=5, B=3 -> rsp_id=1, rsp_data=0x00000001, rsp_carry=1. Then op=3'b010, A=0xFFFFFFFF, B=1 -> rsp_data=0, rsp_carry=1.
- Both requesters valid continuously, rsp_ready=1, 6 cycles -> accepts in order 0,1,0,1,0,1; one response per cycle; rsp_id matches each accept.
- Accept req0, then rsp_ready=0 for 3 cycles with both requesting -> req_ready=0 throughout; rsp_* frozen. rsp_ready=1 -> req1 granted in that same cycle; new response appears next cycle.
- req0 (op=3'b000, A=0xF0F0F0F0, B=0xFF00FF00) accepted; rst_n pulsed low asynchronously mid-cycle -> rsp_valid drops immediately, rsp_data=0. After release, req0 and req1 both valid -> req0 granted first.
- NREQ=3, all requesting, rsp_ready toggling 1,0,1,0 -> grant order 0,1,2,0 only on ready cycles; no requester is skipped.
